tb_run_ctrl: RTL and testbench



---
 rtl/tb_run_ctrl_pkg.sv | 23 ++
 rtl/tb_run_ctrl_if.sv | 34 +++
 rtl/tb_sat_counter.sv | 36 +++
 rtl/tb_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_tb_run_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tb_run_ctrl_pkg.sv
// Shared types and constants for the test-run controller.
package tb_run_ctrl_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned DATA_W  = 32;

   localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

   typedef enum logic [STATE_W-1:0] {
      WAIT = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Sticky verdict flags, updated together on the deciding edge.
   typedef struct packed {
      logic done;
      logic pass;
      logic fail;
      logic timeout;
   } verdict_t;

endpackage

// File: rtl/tb_run_ctrl_if.sv
// Bundle of the subsystem-facing run-control and verdict signals.
interface tb_run_ctrl_if
   import tb_run_ctrl_pkg::*;
(
   input logic clk_i
);

   logic                fetch_enable;
   logic                tests_passed;
   logic                tests_failed;
   logic                exit_valid;
   logic [DATA_W-1:0]   exit_value;
   logic                done;
   logic                pass;
   logic                fail;
   logic                timeout;
   logic [DATA_W-1:0]   result;
   logic [DATA_W-1:0]   cycle_cnt;
   logic [STATE_W-1:0]  state;
   logic                heartbeat;

   // Controller side: consumes subsystem events, produces enable and verdict.
   modport master (
      input  clk_i, tests_passed, tests_failed, exit_valid, exit_value,
      output fetch_enable, done, pass, fail, timeout, result, cycle_cnt, state, heartbeat
   );

   // Subsystem / observer side.
   modport slave (
      input  clk_i, fetch_enable, done, pass, fail, timeout, result, cycle_cnt, state, heartbeat,
      output tests_passed, tests_failed, exit_valid, exit_value
   );

endinterface

// File: rtl/tb_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module tb_sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // Next count: clear wins, otherwise step unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tb_run_ctrl.sv
// Test-run controller: delays fetch enable after reset, then watches the
// subsystem for pass/fail/exit events or a cycle-budget timeout and latches
// a sticky verdict.
// Optional heartbeat pulse: define TB_RUN_CTRL_HEARTBEAT_EN.
module tb_run_ctrl
   import tb_run_ctrl_pkg::*;
#(
   parameter int unsigned FETCH_DELAY    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned HB_PERIOD      = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   output logic                fetch_enable_o,
   input  logic                tests_passed_i,
   input  logic                tests_failed_i,
   input  logic                exit_valid_i,
   input  logic [DATA_W-1:0]   exit_value_i,
   output logic                done_o,
   output logic                pass_o,
   output logic                fail_o,
   output logic                timeout_o,
   output logic [DATA_W-1:0]   result_o,
   output logic [DATA_W-1:0]   cycle_cnt_o,
   output logic [STATE_W-1:0]  state_o,
   output logic                heartbeat_o
);

   localparam logic [DATA_W-1:0] DELAY_LAST = DATA_W'(FETCH_DELAY);
   localparam logic [DATA_W-1:0] RUN_LAST   = DATA_W'(TIMEOUT_CYCLES - 1);

   state_e            state_d, state_q;
   verdict_t          verdict_d, verdict_q;
   logic [DATA_W-1:0] result_d, result_q;
   logic              fetch_en_d, fetch_en_q;
   logic [DATA_W-1:0] delay_cnt;
   logic [DATA_W-1:0] cycle_cnt;

   // Post-reset delay: counts only in WAIT, cleared once WAIT is left.
   tb_sat_counter #(.WIDTH(DATA_W)) u_delay_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (state_q == WAIT),
      .clr_i (state_q != WAIT),
      .cnt_o (delay_cnt)
   );

   // RUN cycle counter: frozen outside RUN, only reset clears it.
   tb_sat_counter #(.WIDTH(DATA_W)) u_cycle_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (state_q == RUN),
      .clr_i (1'b0),
      .cnt_o (cycle_cnt)
   );

   // Next state and verdict; RUN events resolved in fixed priority order.
   always_comb begin
      state_d   = state_q;
      verdict_d = verdict_q;
      result_d  = result_q;
      unique case (state_q)
         WAIT: begin
            if (delay_cnt == DELAY_LAST) state_d = RUN;
         end
         RUN: begin
            if (tests_failed_i) begin
               state_d        = DONE;
               verdict_d.done = 1'b1;
               verdict_d.fail = 1'b1;
               result_d       = '0;
            end else if (exit_valid_i && (exit_value_i != '0)) begin
               state_d        = DONE;
               verdict_d.done = 1'b1;
               verdict_d.fail = 1'b1;
               result_d       = exit_value_i;
            end else if (tests_passed_i) begin
               state_d        = DONE;
               verdict_d.done = 1'b1;
               verdict_d.pass = 1'b1;
               result_d       = '0;
            end else if (exit_valid_i) begin
               state_d        = DONE;
               verdict_d.done = 1'b1;
               verdict_d.pass = 1'b1;
               result_d       = exit_value_i;
            end else if (cycle_cnt == RUN_LAST) begin
               state_d           = DONE;
               verdict_d.done    = 1'b1;
               verdict_d.fail    = 1'b1;
               verdict_d.timeout = 1'b1;
               result_d          = TIMEOUT_RESULT;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d   = WAIT;
            verdict_d = '0;
            result_d  = '0;
         end
      endcase
      fetch_en_d = (state_d != WAIT);
   end

   // Controller registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= WAIT;
         verdict_q  <= '0;
         result_q   <= '0;
         fetch_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         verdict_q  <= verdict_d;
         result_q   <= result_d;
         fetch_en_q <= fetch_en_d;
      end
   end

`ifdef TB_RUN_CTRL_HEARTBEAT_EN
   localparam int unsigned HB_W = $clog2(HB_PERIOD);
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_PERIOD - 1);

   logic [HB_W-1:0] hb_cnt_d, hb_cnt_q;
   logic            hb_d, hb_q;

   // Phase tracker mirrors cycle_cnt modulo HB_PERIOD; pulse when the
   // counter is about to land on a multiple while staying in RUN.
   always_comb begin
      hb_cnt_d = hb_cnt_q;
      hb_d     = 1'b0;
      if (state_q == RUN) begin
         hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + HB_W'(1);
         hb_d     = (state_d == RUN) && (hb_cnt_q == HB_LAST);
      end
   end

   // Heartbeat registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
      end else begin
         hb_cnt_q <= hb_cnt_d;
         hb_q     <= hb_d;
      end
   end

   assign heartbeat_o = hb_q;
`else
   assign heartbeat_o = 1'b0;
`endif

   assign fetch_enable_o = fetch_en_q;
   assign done_o         = verdict_q.done;
   assign pass_o         = verdict_q.pass;
   assign fail_o         = verdict_q.fail;
   assign timeout_o      = verdict_q.timeout;
   assign result_o       = result_q;
   assign cycle_cnt_o    = cycle_cnt;
   assign state_o        = STATE_W'(state_q);

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Scoreboard bench for tb_run_ctrl (FETCH_DELAY=4, TIMEOUT_CYCLES=200,
// HB_PERIOD=8). Heartbeat expectation follows TB_RUN_CTRL_HEARTBEAT_EN.
module tb_tb_run_ctrl;
   import tb_run_ctrl_pkg::*;

   localparam int unsigned FD  = 4;
   localparam int unsigned TO  = 200;
   localparam int unsigned HBP = 8;

   typedef struct {
      logic              done;
      logic              pass;
      logic              fail;
      logic              timeout;
      logic [31:0]       result;
      logic [31:0]       cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   tb_run_ctrl_if ifc (.clk_i(clk));

   tb_run_ctrl #(
      .FETCH_DELAY    (FD),
      .TIMEOUT_CYCLES (TO),
      .HB_PERIOD      (HBP)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .fetch_enable_o (ifc.fetch_enable),
      .tests_passed_i (ifc.tests_passed),
      .tests_failed_i (ifc.tests_failed),
      .exit_valid_i   (ifc.exit_valid),
      .exit_value_i   (ifc.exit_value),
      .done_o         (ifc.done),
      .pass_o         (ifc.pass),
      .fail_o         (ifc.fail),
      .timeout_o      (ifc.timeout),
      .result_o       (ifc.result),
      .cycle_cnt_o    (ifc.cycle_cnt),
      .state_o        (ifc.state),
      .heartbeat_o    (ifc.heartbeat)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic p, input logic f, input logic v, input logic [31:0] val);
      ifc.tests_passed = p;
      ifc.tests_failed = f;
      ifc.exit_valid   = v;
      ifc.exit_value   = val;
   endtask

   // Heartbeat model: one-cycle pulse at nonzero multiples of HBP while in RUN.
   always @(negedge clk) begin
      logic hb_exp;
      if (!rst) begin
`ifdef TB_RUN_CTRL_HEARTBEAT_EN
         hb_exp = (ifc.state == 2'd1) && (ifc.cycle_cnt != 0) && (ifc.cycle_cnt % HBP == 0);
`else
         hb_exp = 1'b0;
`endif
         chk("heartbeat", 32'(ifc.heartbeat), 32'(hb_exp));
      end
   end

   // Assert reset away from a clock edge, check cleared outputs, release.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rst_fe",    32'(ifc.fetch_enable), 32'd0);
      chk("rst_done",  32'(ifc.done),         32'd0);
      chk("rst_pass",  32'(ifc.pass),         32'd0);
      chk("rst_fail",  32'(ifc.fail),         32'd0);
      chk("rst_to",    32'(ifc.timeout),      32'd0);
      chk("rst_res",   ifc.result,            32'd0);
      chk("rst_cnt",   ifc.cycle_cnt,         32'd0);
      chk("rst_state", 32'(ifc.state),        32'd0);
      chk("rst_hb",    32'(ifc.heartbeat),    32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // From reset release: fetch enable must rise on edge FD+1; noisy inputs
   // during WAIT must have no effect.
   task automatic start_run();
      drive(1'b1, 1'b1, 1'b1, 32'h5);
      for (int k = 1; k <= FD + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) drive(1'b0, 1'b0, 1'b0, 32'h0);
         chk("wait_fe", 32'(ifc.fetch_enable), (k == FD + 1) ? 32'd1 : 32'd0);
      end
      chk("run_state", 32'(ifc.state), 32'd1);
      chk("run_done",  32'(ifc.done),  32'd0);
      chk("run_cnt",   ifc.cycle_cnt,  32'd0);
   endtask

   task automatic wait_cnt(input logic [31:0] target);
      int guard = 0;
      while (ifc.cycle_cnt != target && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (ifc.cycle_cnt != target) chk("wait_cnt", ifc.cycle_cnt, target);
   endtask

   // Pop the oldest expectation once done_o is seen (bounded), compare all.
   task automatic collect(input int budget);
      exp_t e;
      int   i = 0;
      while (!ifc.done && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (exp_q.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      if (!ifc.done) begin
         chk("done_wait", 32'(ifc.done), 32'd1);
         return;
      end
      chk("sb_done", 32'(ifc.done),    32'(e.done));
      chk("sb_pass", 32'(ifc.pass),    32'(e.pass));
      chk("sb_fail", 32'(ifc.fail),    32'(e.fail));
      chk("sb_to",   32'(ifc.timeout), 32'(e.timeout));
      chk("sb_res",  ifc.result,       e.result);
      chk("sb_cnt",  ifc.cycle_cnt,    e.cnt);
      chk("sb_st",   32'(ifc.state),   32'd2);
   endtask

   // Drive one event at the given RUN cycle and expect the verdict next edge.
   task automatic fire(input logic [31:0] at, input logic p, input logic f,
                       input logic v, input logic [31:0] val, input exp_t e);
      wait_cnt(at);
      drive(p, f, v, val);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      collect(0);
   endtask

   // Pulse inputs while in DONE and confirm the verdict holds.
   task automatic poke_done(input logic p, input logic f, input logic v,
                            input logic [31:0] val, input exp_t e);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(p, f, v, val);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("hold_pass", 32'(ifc.pass),         32'(e.pass));
      chk("hold_fail", 32'(ifc.fail),         32'(e.fail));
      chk("hold_res",  ifc.result,            e.result);
      chk("hold_cnt",  ifc.cycle_cnt,         e.cnt);
      chk("hold_fe",   32'(ifc.fetch_enable), 32'd1);
   endtask

   initial begin
      exp_t e;
      drive(1'b0, 1'b0, 1'b0, 32'h0);

      // Zero exit code at RUN cycle 100 -> pass, counter frozen at 101.
      do_reset();
      start_run();
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd101};
      fire(32'd100, 1'b0, 1'b0, 1'b1, 32'h0, e);
      poke_done(1'b0, 1'b1, 1'b1, 32'h3, e);

      // Pass and fail together -> fail wins, result 0.
      do_reset();
      start_run();
      e = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'd11};
      fire(32'd10, 1'b1, 1'b1, 1'b0, 32'h0, e);

      // Nonzero exit code 7 -> fail, result 7; later pass pulse ignored.
      do_reset();
      start_run();
      e = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h7, 32'd21};
      fire(32'd20, 1'b0, 1'b0, 1'b1, 32'h7, e);
      poke_done(1'b1, 1'b0, 1'b0, 32'h0, e);

      // Nonzero exit beats a simultaneous pass pulse.
      do_reset();
      start_run();
      e = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h9, 32'd6};
      fire(32'd5, 1'b1, 1'b0, 1'b1, 32'h9, e);

      // Pass pulse on the very first RUN cycle.
      do_reset();
      start_run();
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1};
      fire(32'd0, 1'b1, 1'b0, 1'b0, 32'h0, e);

      // No events -> timeout after TO RUN cycles.
      do_reset();
      start_run();
      e = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'(TO)};
      exp_q.push_back(e);
      collect(TO + 20);
      poke_done(1'b1, 1'b0, 1'b1, 32'h0, e);

      // Zero exit on the timeout cycle wins over timeout.
      do_reset();
      start_run();
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'(TO)};
      fire(32'(TO - 1), 1'b0, 1'b0, 1'b1, 32'h0, e);

      // Reset mid-RUN clears everything and the delay sequence restarts.
      do_reset();
      start_run();
      wait_cnt(32'd30);
      do_reset();
      start_run();
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd4};
      fire(32'd3, 1'b1, 1'b0, 1'b0, 32'h0, e);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
